// File: rtl/race_countdown.sv
// Race start sequencer: 3-2-1-GO countdown that releases the race timer, plus
// the on-screen countdown text lookup for the font ROM.
module race_countdown #(
  parameter int unsigned TICKS_PER_SEC = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        finish,
  input  logic        refresh_tick,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic        pause,
  output logic        race_clear,
  output logic        race_active,
  output logic        count_on,
  output logic [2:0]  bit_addr,
  output logic [10:0] rom_addr,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CD3  = 3'd1,
    CD2  = 3'd2,
    CD1  = 3'd3,
    GO   = 3'd4,
    RACE = 3'd5
  } state_t;

  localparam logic [26:0] LAST_STEP = 27'(TICKS_PER_SEC - 1);

  state_t      state, state_nxt, disp_state;
  logic [26:0] step_cnt;
  logic        start_q;
  logic        start_rise;
  logic        last_step;
  logic        clear_nxt;

  assign start_rise = start & ~start_q;
  assign last_step  = (step_cnt == LAST_STEP);

  always_comb begin
    state_nxt = state;
    clear_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_nxt = CD3;
          clear_nxt = 1'b1;
        end
      end
      CD3:     if (last_step) state_nxt = CD2;
      CD2:     if (last_step) state_nxt = CD1;
      CD1:     if (last_step) state_nxt = GO;
      // finish outranks the GO terminal count
      GO: begin
        if (finish)         state_nxt = IDLE;
        else if (last_step) state_nxt = RACE;
      end
      RACE:    if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pause/race_active are registered from the next state so they move with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      step_cnt    <= '0;
      start_q     <= 1'b0;
      pause       <= 1'b1;
      race_clear  <= 1'b0;
      race_active <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_q     <= start;
      race_clear  <= clear_nxt;
      pause       <= (state_nxt == IDLE) || (state_nxt == CD3) ||
                     (state_nxt == CD2)  || (state_nxt == CD1);
      race_active <= (state_nxt == GO) || (state_nxt == RACE);
      if ((state_nxt != state) || (state_nxt == IDLE) || (state_nxt == RACE))
        step_cnt <= '0;
      else
        step_cnt <= step_cnt + 27'd1;
    end
  end

  // Text follows a frame-aligned copy of the state so a character never tears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            disp_state <= IDLE;
    else if (refresh_tick) disp_state <= state;
  end

  logic       in_text;
  logic [1:0] char_idx;
  logic [6:0] char_code;
  logic       unused_pix;

  assign in_text  = (pix_y[9:5] == 5'd7) && (pix_x[9:4] >= 6'd18) && (pix_x[9:4] <= 6'd21);
  assign char_idx = pix_x[5:4] - 2'd2;

  always_comb begin
    char_code = 7'h00;
    case (disp_state)
      CD3: if (char_idx == 2'd0) char_code = {3'b011, 4'd3};
      CD2: if (char_idx == 2'd0) char_code = {3'b011, 4'd2};
      CD1: if (char_idx == 2'd0) char_code = {3'b011, 4'd1};
      GO: begin
        case (char_idx)
          2'd0:    char_code = 7'h47;
          2'd1:    char_code = 7'h4f;
          2'd2:    char_code = 7'h21;
          default: char_code = 7'h00;
        endcase
      end
      default: char_code = 7'h00;
    endcase
  end

  assign count_on   = reset & in_text &
                      ((disp_state == CD3) || (disp_state == CD2) ||
                       (disp_state == CD1) || (disp_state == GO));
  assign rom_addr   = {char_code, pix_y[4:1]};
  assign bit_addr   = pix_x[3:1];
  assign state_dbg  = state;
  assign unused_pix = pix_x[0] ^ pix_y[0];

endmodule

// File: tb/tb_race_countdown.sv
// Bench for race_countdown: directed race scenarios plus random traffic, all
// checked against a phase/time-left reference model through an expected queue.
module tb_race_countdown;

  localparam int TICKS = 4;

  logic        clk = 1'b0;
  logic        reset, start, finish, refresh_tick;
  logic [9:0]  pix_x, pix_y;
  logic        pause, race_clear, race_active, count_on;
  logic [2:0]  bit_addr, state_dbg;
  logic [10:0] rom_addr;

  int total = 0;
  int bad   = 0;

  // {state[2:0], pause, race_clear, race_active, count_on, bit_addr[2:0], rom_addr[10:0]}
  logic [20:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  race_countdown #(.TICKS_PER_SEC(TICKS)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .refresh_tick(refresh_tick), .pix_x(pix_x), .pix_y(pix_y),
    .pause(pause), .race_clear(race_clear), .race_active(race_active),
    .count_on(count_on), .bit_addr(bit_addr), .rom_addr(rom_addr),
    .state_dbg(state_dbg)
  );

  // reference model: phase 0 idle, 1..3 showing 3/2/1, 4 go, 5 racing
  int m_phase, m_left, m_disp;
  bit m_prev, m_clear;

  function automatic void model_reset();
    m_phase = 0; m_left = 0; m_disp = 0; m_prev = 0; m_clear = 0;
  endfunction

  function automatic void model_edge();
    int  old_phase;
    bit  rise;
    if (!reset) begin
      model_reset();
      return;
    end
    old_phase = m_phase;
    rise      = start && !m_prev;
    m_prev    = start;
    m_clear   = 0;
    if (refresh_tick) m_disp = old_phase;
    if (m_phase == 0) begin
      if (rise) begin m_phase = 1; m_left = TICKS; m_clear = 1; end
    end else if (m_phase <= 3) begin
      m_left--;
      if (m_left == 0) begin m_phase++; m_left = TICKS; end
    end else if (m_phase == 4) begin
      if (finish) m_phase = 0;
      else begin
        m_left--;
        if (m_left == 0) m_phase = 5;
      end
    end else if (finish) begin
      m_phase = 0;
    end
  endfunction

  function automatic logic [20:0] expect_now();
    int cx, cy, idx, ch, rom;
    bit on;
    cx  = int'(pix_x) / 16;
    cy  = int'(pix_y) / 32;
    idx = (cx % 4 + 2) % 4;
    ch  = 0;
    case (m_disp)
      1: if (idx == 0) ch = 'h33;
      2: if (idx == 0) ch = 'h32;
      3: if (idx == 0) ch = 'h31;
      4: ch = (idx == 0) ? 'h47 : (idx == 1) ? 'h4f : (idx == 2) ? 'h21 : 0;
      default: ch = 0;
    endcase
    on  = reset && (cy == 7) && (cx >= 18) && (cx <= 21) && (m_disp >= 1) && (m_disp <= 4);
    rom = ch * 16 + (int'(pix_y) % 32) / 2;
    return {3'(m_phase), (m_phase < 4), m_clear, (m_phase >= 4), on,
            3'((int'(pix_x) % 16) / 2), 11'(rom)};
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: advance one clock, then apply the next inputs and queue the expectation
  task automatic step(input logic st, input logic fi, input logic rt,
                      input logic [9:0] x, input logic [9:0] y, input logic rs);
    @(posedge clk);
    #1;
    model_edge();
    start = st; finish = fi; refresh_tick = rt; pix_x = x; pix_y = y; reset = rs;
    if (!rs) model_reset();
    exp_q.push_back(expect_now());
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [20:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state",       state_dbg,   e[20:18]);
      check("pause",       pause,       e[17]);
      check("race_clear",  race_clear,  e[16]);
      check("race_active", race_active, e[15]);
      check("count_on",    count_on,    e[14]);
      check("bit_addr",    bit_addr,    e[13:11]);
      check("rom_addr",    rom_addr,    e[10:0]);
    end
  end

  initial begin
    int  clears;
    logic st;
    reset = 1'b0; start = 1'b0; finish = 1'b0; refresh_tick = 1'b0;
    pix_x = 10'd288; pix_y = 10'd230;
    model_reset();

    // held in reset with refresh and pixels in the text area
    step(0, 0, 1, 288, 230, 0);
    step(0, 0, 1, 288, 230, 0);
    @(negedge clk);
    check("rst_count_on", count_on, 0);
    check("rst_pause", pause, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 288, 230, 1);

    // full countdown, display lookups, ignored start/finish, finish in race
    step(1, 0, 0, 288, 230, 1);
    for (int k = 1; k <= 20; k++) begin
      step((k == 5) ? 1'b0 : 1'b1, (k == 9 || k == 18), (k == 2 || k == 5),
           (k == 7) ? 10'd304 : 10'd288, 230, 1);
      @(negedge clk);
      if (k == 1)  check("a_clear_on", race_clear, 1);
      if (k == 2)  check("a_clear_off", race_clear, 0);
      if (k == 3)  check("a_rom_cd3", rom_addr, 11'h333);
      if (k == 3)  check("a_on_cd3", count_on, 1);
      if (k == 5)  check("a_state_cd2", state_dbg, 2);
      if (k == 5)  check("a_rom_stale", rom_addr, 11'h333);
      if (k == 6)  check("a_rom_cd2", rom_addr, 11'h323);
      if (k == 6)  check("a_on_cd2", count_on, 1);
      if (k == 6)  check("a_bit_cd2", bit_addr, 0);
      if (k == 7)  check("a_rom_blank", rom_addr, 11'h003);
      if (k == 9)  check("a_state_cd1", state_dbg, 3);
      if (k == 10) check("a_finish_cd1", state_dbg, 3);
      if (k == 12) check("a_pause_cd1", pause, 1);
      if (k == 13) check("a_pause_go", pause, 0);
      if (k == 13) check("a_state_go", state_dbg, 4);
      if (k == 17) check("a_state_race", state_dbg, 5);
      if (k == 19) check("a_state_idle", state_dbg, 0);
      if (k == 19) check("a_pause_idle", pause, 1);
      if (k == 19) check("a_active_idle", race_active, 0);
      if (k == 20) check("a_no_retrigger", state_dbg, 0);
    end

    // finish on the same edge as the GO terminal count
    step(0, 0, 0, 100, 100, 1);
    step(1, 0, 0, 100, 100, 1);
    for (int k = 1; k <= 17; k++) begin
      step(1, (k == 16), 0, 100, 100, 1);
      @(negedge clk);
      if (k == 16) check("b_state_go", state_dbg, 4);
      if (k == 17) check("b_go_finish", state_dbg, 0);
    end

    // reset during CD1 aborts at once; a new edge is needed afterwards
    step(0, 0, 0, 288, 230, 1);
    step(1, 0, 0, 288, 230, 1);
    for (int k = 1; k <= 9; k++) step(1, 0, 0, 288, 230, 1);
    step(1, 0, 0, 288, 230, 0);
    #1;
    check("c_rst_pause", pause, 1);
    check("c_rst_state", state_dbg, 0);
    check("c_rst_clear", race_clear, 0);
    check("c_rst_count_on", count_on, 0);
    step(0, 0, 0, 288, 230, 0);
    step(0, 0, 0, 288, 230, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 288, 230, 1);
    @(negedge clk);
    check("c_stay_idle", state_dbg, 0);
    step(1, 0, 0, 288, 230, 1);
    step(1, 0, 0, 288, 230, 1);
    @(negedge clk);
    check("c_restart", state_dbg, 1);
    check("c_restart_clear", race_clear, 1);

    // let that race start, end it, then hold start for 40 cycles
    for (int i = 0; i < 20; i++) step(1, 0, 0, 50, 50, 1);
    step(0, 1, 0, 50, 50, 1);
    step(0, 0, 0, 50, 50, 1);
    clears = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, ($urandom_range(0, 1) == 0), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 1);
      @(negedge clk);
      if (race_clear) clears++;
    end
    check("d_clear_count", clears, 1);
    check("d_state_race", state_dbg, 5);
    step(1, 1, 0, 50, 50, 1);
    step(1, 0, 0, 50, 50, 1);

    // random traffic
    st = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      logic [9:0] x, y;
      if ($urandom_range(0, 7) == 0) st = ~st;
      if ($urandom_range(0, 1) == 0) begin
        x = 10'(288 + $urandom_range(0, 63));
        y = 10'(224 + $urandom_range(0, 31));
      end else begin
        x = 10'($urandom_range(0, 1023));
        y = 10'($urandom_range(0, 1023));
      end
      step(st, ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0), x, y,
           ($urandom_range(0, 299) != 0));
    end

    step(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/race_countdown.md
RACE_COUNTDOWN -- requirements
Module: race_countdown

Interface
REQ-001 Parameter: TICKS_PER_SEC, default 100000000, clock cycles per countdown step (1 s at 100 MHz).
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low; low forces reset state immediately.
REQ-004 Port: start  input  1  race start request, level from the debounced button.
REQ-005 Port: finish  input  1  race-over indication, level.
REQ-006 Port: refresh_tick  input  1  one-cycle frame-start pulse from VGA sync.
REQ-007 Port: pix_x, pix_y  input  10 each  current pixel coordinates.
REQ-008 Port: pause  output  1  high holds the race timer.
REQ-009 Port: race_clear  output  1  one-cycle pulse that zeroes the race timer.
REQ-010 Port: race_active  output  1  high while the race runs (GO and RACE states).
REQ-011 Port: count_on  output  1  countdown text pixel region active.
REQ-012 Port: bit_addr  output  3  font column select.
REQ-013 Port: rom_addr  output  11  font ROM address, {char code[6:0], row[3:0]}.

Function
REQ-014 The FSM SHALL have states IDLE, CD3, CD2, CD1, GO, RACE.
REQ-015 Start detection SHALL use a registered rising edge of start; level-held start SHALL NOT retrigger.
REQ-016 IDLE -> CD3 on a start rising edge; race_clear SHALL pulse high in the same cycle the state becomes CD3.
REQ-017 CD3 -> CD2 -> CD1 -> GO -> RACE, each transition after exactly TICKS_PER_SEC cycles in the current state.
REQ-018 Step counter: 27 bits, cleared on every state change, counts 0..TICKS_PER_SEC-1, held at 0 in IDLE and RACE.
REQ-019 Start edges outside IDLE SHALL be ignored.
REQ-020 finish high in GO or RACE SHALL return the FSM to IDLE on the next edge; finish in IDLE/CD3/CD2/CD1 SHALL be ignored.
REQ-021 pause = 1 in IDLE, CD3, CD2, CD1; 0 in GO, RACE; pause and race_active SHALL be registered outputs changing in the same cycle as the state.
REQ-022 Display state register SHALL copy FSM state only on refresh_tick cycles; text content SHALL derive from the display state only.
REQ-023 Text region: pix_y[9:5] == 7 and pix_x[9:4] in 18..21 (4 characters, 16x32 pixels each).
REQ-024 count_on = text region AND display state in {CD3, CD2, CD1, GO}; combinational from pix inputs.
REQ-025 Character index = pix_x[5:4] - 2 (mod 4): index 0..3 left to right.
REQ-026 Characters: CD3 "3" at index 0; CD2 "2"; CD1 "1"; GO "GO!" at 0..2; all other positions/states code 7'h00.
REQ-027 Digit codes SHALL be {3'b011, digit}; 'G' = 7'h47, 'O' = 7'h4f, '!' = 7'h21.
REQ-028 rom_addr = {char code, pix_y[4:1]}; bit_addr = pix_x[3:1].
REQ-029 Step-counter terminal count and finish in the same cycle in GO: finish wins, next state IDLE.

Reset
REQ-030 Reset low SHALL set state IDLE, display state IDLE, step counter 0, start-edge register 0, pause 1, race_clear 0, race_active 0.
REQ-031 Reset asserted mid-countdown SHALL abort immediately with no race_clear pulse; after release, a fresh start edge is required.
REQ-032 count_on SHALL be 0 under reset for all pix inputs.

Verification (TICKS_PER_SEC = 4)
REQ-033 Reset release, start rises at cycle 10 -> race_clear single pulse in CD3 entry cycle; CD2 +4, CD1 +8, GO +12, RACE +16; pause falls at +12.
REQ-034 start held high 40 cycles -> exactly one countdown, one race_clear pulse.
REQ-035 start edge during CD2 -> ignored, timing unchanged; finish in CD1 -> ignored.
REQ-036 finish in RACE -> IDLE next cycle, pause 1, race_active 0; finish coinciding with GO terminal count -> IDLE.
REQ-037 In CD2 after refresh_tick, pix_x=288, pix_y=230 -> count_on 1, rom_addr = {7'h32, 4'h3}, bit_addr 0; pix_x=304 -> rom_addr char 7'h00; before refresh_tick display still CD3 ('3' = 7'h33).
REQ-038 Reset low during CD1 -> pause 1, state IDLE asynchronously, race_clear stays 0.
